front_panel_trig_n: RTL and testbench
=====================================

// Module: front_panel_trig_n
// PURPOSE
//  Parametrised front-panel switch sequencer: synchronises NSW raw switch lines, fires one
//  qualified trigger pulse with a latched switch snapshot, debounces, then requires release
//  before re-arming. Optional hold-to-repeat per switch (e.g. DEP/EXAM auto-step).
//  Sits between panel switch pins and the CPU state machine; the CPU supplies arm_mask per state.
// PARAMETERS
//  NSW          7    number of switch channels
//  SYNC_STAGES  2    synchroniser flops per channel (>=2)
//  PULSE_LEN    4    cycles trig/swd held valid (>=1)
//  DBNCE_BITS   12   holdoff = 2**(DBNCE_BITS-1) cycles after pulse
//  RPT_BITS     20   repeat interval = 2**(RPT_BITS-1) cycles while held
// PORTS
//  clk         in   1     system clock
//  reset       in   1     asynchronous, active-low reset
//  sw          in   NSW   raw switch levels, asynchronous, 1 = pressed
//  arm_mask    in   NSW   1 = channel may fire in the current CPU state
//  rpt_mask    in   NSW   1 = channel auto-repeats while held
//  trig        out  1     high for PULSE_LEN cycles per accepted press
//  swd         out  NSW   snapshot (sync_sw & arm_mask) at accept; valid while trig=1, else 0
//  busy        out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, counters=0, sync flops=0, trig=0, swd=0, busy=0.
//  s = sw after SYNC_STAGES flops; hit = s & arm_mask.
//  IDLE:    hit!=0 -> PULSE; swd<=hit, trig<=1, pcnt<=0. Several bits at once: all latched, one pulse.
//  PULSE:   trig=1, swd held; pcnt++; pcnt==PULSE_LEN-1 -> HOLDOFF, trig<=0, swd<=0, dcnt<=0.
//           arm_mask/sw changes ignored during PULSE.
//  HOLDOFF: dcnt++; dcnt MSB==1 -> RELEASE, rcnt<=0. trig=0, swd=0.
//  RELEASE: s==0 -> IDLE (edge semantics: held switch never re-fires without repeat).
//           else if (s & swd_last & rpt_mask)!=0, rcnt++; rcnt MSB==1 -> PULSE with
//           swd<=s & swd_last & rpt_mask & arm_mask (if that is 0, stay, rcnt<=0).
//           swd_last = internal copy of last snapshot; any other switch newly pressed
//           while held is ignored until full release.
//  Counters are plain binary, wrap not reachable (exit on MSB). No state other than IDLE
//  accepts a press. Illegal FSM encoding -> IDLE next cycle.
//  trig/swd registered; latency raw edge -> trig = SYNC_STAGES+1 cycles.
//  Reset asserted mid-pulse: trig and swd drop immediately (async), no partial pulse on release.
// STRUCTURE
//  FSM encodings (IDLE,PULSE,HOLDOFF,RELEASE) as localparams in shared parameters.v
//  alongside existing CPU state codes (H0,F0,D0,E0); callers build arm_mask from those.
//  One sub-module: fp_sync (NSW-wide, SYNC_STAGES-deep synchroniser, async active-low reset).
// TESTING  (NSW=7, SYNC_STAGES=2, PULSE_LEN=4, DBNCE_BITS=4, RPT_BITS=5)
//  1 sw=7'b0000100, arm_mask=7'h7F -> trig=1 on cycle 3 for 4 cycles, swd=7'b0000100, then 0.
//  2 hold sw=7'b0000100, rpt_mask=0 for 200 cycles -> exactly one pulse; busy until release+1.
//  3 hold sw=7'b0000010, rpt_mask=7'b0000010 -> pulses every 4+8+16 cycles, swd=7'b0000010.
//  4 sw=7'b0011000 same cycle, arm_mask=7'b0001000 -> one pulse, swd=7'b0001000.
//  5 arm_mask=0, sw=7'h01 -> no trig, busy=0; set arm_mask=7'h01 while held -> pulse follows.
//  6 reset=0 on 2nd PULSE cycle -> trig/swd=0 same cycle; after reset=1 with sw held -> new pulse.

Source files
------------

// File: rtl/front_panel_trig_n_pkg.sv
// Shared encodings for the front-panel switch sequencer and the CPU state codes
// that callers use when building arm_mask.
package front_panel_trig_n_pkg;

    typedef enum logic [1:0] {
        FP_IDLE    = 2'd0,
        FP_PULSE   = 2'd1,
        FP_HOLDOFF = 2'd2,
        FP_RELEASE = 2'd3
    } fp_state_e;

    localparam logic [1:0] CPU_H0 = 2'd0;
    localparam logic [1:0] CPU_F0 = 2'd1;
    localparam logic [1:0] CPU_D0 = 2'd2;
    localparam logic [1:0] CPU_E0 = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_sync.sv
// NSW-wide multi-flop synchroniser for raw asynchronous switch levels.
module fp_sync #(
    parameter int NSW         = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NSW-1:0] i_d,
    output logic [NSW-1:0] o_q
);

    logic [SYNC_STAGES-1:0][NSW-1:0] r_stg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_stg <= '0;
        else        r_stg <= {r_stg[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_stg[SYNC_STAGES-1];

endmodule

// File: rtl/front_panel_trig_n.sv
// Front-panel switch sequencer: one qualified trigger pulse with snapshot per press,
// debounce holdoff, release-before-rearm, optional hold-to-repeat per channel.
module front_panel_trig_n #(
    parameter int NSW         = 7,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 4,
    parameter int DBNCE_BITS  = 12,
    parameter int RPT_BITS    = 20
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NSW-1:0] sw,
    input  logic [NSW-1:0] arm_mask,
    input  logic [NSW-1:0] rpt_mask,
    output logic           trig,
    output logic [NSW-1:0] swd,
    output logic           busy
);
    import front_panel_trig_n_pkg::*;

    localparam int PCW = cnt_w(PULSE_LEN);

    fp_state_e             r_state, w_state_nxt;
    logic [PCW-1:0]        r_pcnt, w_pcnt_nxt;
    logic [DBNCE_BITS-1:0] r_dcnt, w_dcnt_nxt, w_dinc;
    logic [RPT_BITS-1:0]   r_rcnt, w_rcnt_nxt, w_rinc;
    logic [NSW-1:0]        r_swd, w_swd_nxt, r_swd_last, w_last_nxt;
    logic                  r_trig, w_trig_nxt;
    logic [NSW-1:0]        w_s, w_hit, w_rpt, w_rhit;

    fp_sync #(.NSW(NSW), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (sw),
        .o_q   (w_s)
    );

    assign w_hit  = w_s & arm_mask;
    assign w_rpt  = w_s & r_swd_last & rpt_mask;
    assign w_rhit = w_rpt & arm_mask;
    // Exit on the incremented value's MSB so holdoff/repeat last exactly 2**(N-1) cycles.
    assign w_dinc = r_dcnt + 1'b1;
    assign w_rinc = r_rcnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FP_IDLE;
            r_pcnt     <= '0;
            r_dcnt     <= '0;
            r_rcnt     <= '0;
            r_swd      <= '0;
            r_swd_last <= '0;
            r_trig     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_swd      <= w_swd_nxt;
            r_swd_last <= w_last_nxt;
            r_trig     <= w_trig_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_dcnt_nxt  = r_dcnt;
        w_rcnt_nxt  = r_rcnt;
        w_swd_nxt   = '0;
        w_last_nxt  = r_swd_last;
        w_trig_nxt  = 1'b0;
        case (r_state)
            FP_IDLE: begin
                if (|w_hit) begin
                    w_state_nxt = FP_PULSE;
                    w_swd_nxt   = w_hit;
                    w_last_nxt  = w_hit;
                    w_trig_nxt  = 1'b1;
                    w_pcnt_nxt  = '0;
                end
            end
            FP_PULSE: begin
                if (r_pcnt == PCW'(PULSE_LEN - 1)) begin
                    w_state_nxt = FP_HOLDOFF;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt  = r_pcnt + 1'b1;
                    w_swd_nxt   = r_swd;
                    w_trig_nxt  = 1'b1;
                end
            end
            FP_HOLDOFF: begin
                w_dcnt_nxt = w_dinc;
                if (w_dinc[DBNCE_BITS-1]) begin
                    w_state_nxt = FP_RELEASE;
                    w_rcnt_nxt  = '0;
                end
            end
            FP_RELEASE: begin
                if (w_s == '0) begin
                    w_state_nxt = FP_IDLE;
                end else if (|w_rpt) begin
                    w_rcnt_nxt = w_rinc;
                    if (w_rinc[RPT_BITS-1]) begin
                        w_rcnt_nxt = '0;
                        if (|w_rhit) begin
                            w_state_nxt = FP_PULSE;
                            w_swd_nxt   = w_rhit;
                            w_last_nxt  = w_rhit;
                            w_trig_nxt  = 1'b1;
                            w_pcnt_nxt  = '0;
                        end
                    end
                end else begin
                    // Held, but nothing eligible to repeat: keep waiting for full release.
                    w_rcnt_nxt = '0;
                end
            end
            default: w_state_nxt = FP_IDLE;
        endcase
    end

    assign trig = r_trig;
    assign swd  = r_swd;
    assign busy = (r_state != FP_IDLE);

endmodule

// File: tb/tb_front_panel_trig_n.sv
// Directed-vector bench for front_panel_trig_n with short debounce/repeat counters.
module tb_front_panel_trig_n;

    localparam int NSW = 7;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NSW-1:0] sw = '0, arm_mask = '0, rpt_mask = '0;
    logic           trig;
    logic [NSW-1:0] swd;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    front_panel_trig_n #(
        .NSW(NSW), .SYNC_STAGES(2), .PULSE_LEN(4), .DBNCE_BITS(4), .RPT_BITS(5)
    ) dut (
        .clk(clk), .reset(reset), .sw(sw), .arm_mask(arm_mask), .rpt_mask(rpt_mask),
        .trig(trig), .swd(swd), .busy(busy)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 64) begin tick(1); k++; end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL %s idle timeout: busy=%b exp 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; sw = 7'h7F; arm_mask = 7'h7F;
        tick(3);
        vectors++;
        if ({trig, swd, busy} !== 9'b0) begin
            miscompares++; $display("FAIL reset: trig=%b swd=%h busy=%b exp all 0", trig, swd, busy);
        end
        sw = '0;
        reset = 1'b1;
        tick(3);
    endtask

    task automatic test_single();
        arm_mask = 7'h7F; rpt_mask = '0; sw = 7'b0000100;
        tick(2);
        vectors++;
        if (trig !== 1'b0) begin
            miscompares++; $display("FAIL single early: trig=%b exp 0", trig);
        end
        tick(1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (trig !== 1'b1 || swd !== 7'b0000100) begin
                miscompares++; $display("FAIL single pulse[%0d]: trig=%b swd=%b exp 1/0000100", i, trig, swd);
            end
            tick(1);
        end
        vectors++;
        if (trig !== 1'b0 || swd !== 7'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL single end: trig=%b swd=%b busy=%b exp 0/0/1", trig, swd, busy);
        end
        sw = '0;
        wait_idle("single");
    endtask

    task automatic test_hold_no_repeat();
        int rises = 0;
        logic prev = 1'b0;
        sw = 7'b0000100; rpt_mask = '0;
        for (int t = 0; t < 200; t++) begin
            tick(1);
            if (trig && !prev) rises++;
            prev = trig;
        end
        vectors++;
        if (rises !== 1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL hold pulses: rises=%0d busy=%b exp 1/1", rises, busy);
        end
        sw = '0;
        tick(2);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL hold busy late: busy=%b exp 1", busy);
        end
        tick(1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL hold release: busy=%b exp 0", busy);
        end
    endtask

    task automatic test_repeat();
        int rises = 0;
        int exp_t = 3;
        logic prev = 1'b0;
        sw = 7'b0000010; rpt_mask = 7'b0000010; arm_mask = 7'h7F;
        for (int t = 1; t <= 90; t++) begin
            tick(1);
            if (trig && !prev) begin
                vectors++;
                if (t != exp_t) begin
                    miscompares++; $display("FAIL repeat rise: cycle=%0d exp %0d", t, exp_t);
                end
                exp_t += 28;
                rises++;
            end
            if (trig) begin
                vectors++;
                if (swd !== 7'b0000010) begin
                    miscompares++; $display("FAIL repeat swd: swd=%b exp 0000010", swd);
                end
            end
            prev = trig;
        end
        vectors++;
        if (rises != 4) begin
            miscompares++; $display("FAIL repeat count: rises=%0d exp 4", rises);
        end
        sw = '0; rpt_mask = '0;
        wait_idle("repeat");
    endtask

    task automatic test_multi();
        arm_mask = 7'b0001000; sw = 7'b0011000;
        tick(3);
        vectors++;
        if (trig !== 1'b1 || swd !== 7'b0001000) begin
            miscompares++; $display("FAIL multi pulse: trig=%b swd=%b exp 1/0001000", trig, swd);
        end
        tick(4);
        vectors++;
        if (trig !== 1'b0 || swd !== 7'b0) begin
            miscompares++; $display("FAIL multi end: trig=%b swd=%b exp 0/0", trig, swd);
        end
        sw = '0; arm_mask = 7'h7F;
        wait_idle("multi");
    endtask

    task automatic test_arm_late();
        arm_mask = '0; sw = 7'h01;
        tick(10);
        vectors++;
        if (trig !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL unarmed: trig=%b busy=%b exp 0/0", trig, busy);
        end
        arm_mask = 7'h01;
        tick(1);
        vectors++;
        if (trig !== 1'b1 || swd !== 7'h01) begin
            miscompares++; $display("FAIL arm late: trig=%b swd=%h exp 1/01", trig, swd);
        end
        sw = '0; arm_mask = 7'h7F;
        wait_idle("arm_late");
    endtask

    task automatic test_reset_mid();
        sw = 7'b0000100; arm_mask = 7'h7F;
        tick(4);
        vectors++;
        if (trig !== 1'b1) begin
            miscompares++; $display("FAIL mid pre: trig=%b exp 1", trig);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (trig !== 1'b0 || swd !== 7'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid reset: trig=%b swd=%b busy=%b exp 0/0/0", trig, swd, busy);
        end
        #2 reset = 1'b1;
        tick(3);
        vectors++;
        if (trig !== 1'b1 || swd !== 7'b0000100) begin
            miscompares++; $display("FAIL mid repulse: trig=%b swd=%b exp 1/0000100", trig, swd);
        end
        sw = '0;
        wait_idle("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_no_repeat();
        test_repeat();
        test_multi();
        test_arm_late();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
